// File: rtl/layer_tm_if.sv
// Stream and configuration bundle for layer_tm: weight/bias writes, x input stream,
// serialised neuron output stream and argmax result.
interface layer_tm_if #(
  parameter int unsigned DataW = 16,
  parameter int unsigned IdxW  = 5
);
  logic              weightValid;
  logic              biasValid;
  logic [31:0]       weightValue;
  logic [31:0]       biasValue;
  logic [31:0]       config_layer_num;
  logic [31:0]       config_neuron_num;
  logic              x_valid;
  logic              x_ready;
  logic [DataW-1:0]  x_in;
  logic              out_valid;
  logic              out_ready;
  logic [DataW-1:0]  out_data;
  logic [IdxW-1:0]   out_idx;
  logic              out_last;
  logic              argmax_valid;
  logic [IdxW-1:0]   argmax_idx;

  modport master (
    output weightValid, biasValid, weightValue, biasValue, config_layer_num,
           config_neuron_num, x_valid, x_in, out_ready,
    input  x_ready, out_valid, out_data, out_idx, out_last, argmax_valid, argmax_idx
  );

  modport slave (
    input  weightValid, biasValid, weightValue, biasValue, config_layer_num,
           config_neuron_num, x_valid, x_in, out_ready,
    output x_ready, out_valid, out_data, out_idx, out_last, argmax_valid, argmax_idx
  );
endinterface

// File: rtl/layer_tm.sv
// Time-multiplexed fully-connected layer: NN neurons over PAR shared MAC lanes.
// Optional argmax tracker on the output stream is enabled by LAYER_TM_ARGMAX_EN.
module layer_tm #(
  parameter int unsigned NN        = 30,
  parameter int unsigned NUM_IN    = 784,
  parameter int unsigned PAR       = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 12,
  parameter int unsigned LAYER_NUM = 2,
  parameter string       ACT       = "relu"
) (
  input logic         clk,
  input logic         rst,
  layer_tm_if.slave   bus_io
);

  localparam int unsigned NG    = (NN + PAR - 1) / PAR;
  localparam int unsigned IdxW  = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned Depth = NG * NUM_IN;
  localparam int unsigned BaW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(NUM_IN + 2) + 1;
  localparam int unsigned LaneW = (PAR > 1) ? $clog2(PAR) : 1;
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned AccW  = 2 * DATA_W + $clog2(NUM_IN) + 1;
  localparam bit          ReluEn = (ACT == "relu");

  localparam logic signed [AccW-1:0] MaxV = {{(AccW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinV = {{(AccW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StBias, StEmit} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          cnt_q, c_q;
  logic [LaneW-1:0]         lane_q;
  logic [31:0]              nbase_q, rbase_q;
  logic                     rd_v_q;
  logic signed [AccW-1:0]   acc_q [PAR];
  logic signed [DATA_W-1:0] res_q [PAR];
  logic                     x_ready_q, out_valid_q, out_last_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic [IdxW-1:0]          out_idx_q;
  logic [CntW-1:0]          wcnt_q, wcnt_d;
  logic [31:0]              prev_n_q;

  logic signed [DATA_W-1:0] ibuf_q [NUM_IN];
  logic signed [DATA_W-1:0] wmem_q [PAR][Depth];
  logic signed [DATA_W-1:0] bias_q [NN];
  logic signed [DATA_W-1:0] rd_q [PAR];
  logic signed [DATA_W-1:0] xr_q;

  logic                     cfg_ok, w_we, b_we, beat;
  logic [31:0]              cfg_bank, cfg_row, cur_n;
  logic [CntW-1:0]          widx, ck;
  logic [BaW-1:0]           waddr, raddr;
  logic [LaneW-1:0]         nxt_lane;
  logic signed [PW-1:0]     prod [PAR];
  logic signed [DATA_W-1:0] bres [PAR];
  logic                     unused_hi;

  assign unused_hi = ^{bus_io.weightValue[31:DATA_W], bus_io.biasValue[31:DATA_W]};

  // Rescale, saturate and activate one accumulator with its bias.
  function automatic logic signed [DATA_W-1:0] post(input logic signed [AccW-1:0] acc,
                                                    input logic signed [DATA_W-1:0] b);
    logic signed [AccW-1:0]   s;
    logic signed [DATA_W-1:0] r;
    s = acc + (AccW'(b) <<< FRAC_W);
    s = s >>> FRAC_W;
    if (s > MaxV) begin
      s = MaxV;
    end else if (s < MinV) begin
      s = MinV;
    end
    r = s[DATA_W-1:0];
    if (ReluEn && r[DATA_W-1]) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    cfg_ok   = !rst && (state_q == StIdle) && (bus_io.config_layer_num == 32'(LAYER_NUM)) &&
               (bus_io.config_neuron_num < NN);
    w_we     = cfg_ok && bus_io.weightValid;
    b_we     = cfg_ok && bus_io.biasValid;
    cfg_bank = bus_io.config_neuron_num % PAR;
    cfg_row  = bus_io.config_neuron_num / PAR;
    // Element counter restarts whenever the target neuron changes.
    widx     = (bus_io.config_neuron_num != prev_n_q) ? '0 : wcnt_q;
    waddr    = BaW'(cfg_row * NUM_IN + 32'(widx));
    wcnt_d   = (widx == CntW'(NUM_IN - 1)) ? '0 : widx + CntW'(1);
    beat     = !rst && bus_io.x_valid && x_ready_q;
    ck       = (c_q < CntW'(NUM_IN)) ? c_q : '0;
    raddr    = BaW'(rbase_q + 32'(ck));
    cur_n    = nbase_q + 32'(lane_q);
    nxt_lane = lane_q + LaneW'(1);
    for (int l = 0; l < PAR; l++) begin
      prod[l] = PW'(xr_q) * PW'(rd_q[l]);
      bres[l] = post(acc_q[l], ((nbase_q + 32'(l)) < NN) ?
                               bias_q[IdxW'(nbase_q + 32'(l))] : '0);
    end
  end

  // Storage arrays: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (beat) begin
      ibuf_q[cnt_q] <= bus_io.x_in;
    end
    if (b_we) begin
      bias_q[IdxW'(bus_io.config_neuron_num)] <= bus_io.biasValue[DATA_W-1:0];
    end
    for (int l = 0; l < PAR; l++) begin
      if (w_we && (cfg_bank == 32'(l))) begin
        wmem_q[l][waddr] <= bus_io.weightValue[DATA_W-1:0];
      end
      rd_q[l] <= wmem_q[l][raddr];
    end
    xr_q <= ibuf_q[ck];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      c_q         <= '0;
      lane_q      <= '0;
      nbase_q     <= '0;
      rbase_q     <= '0;
      rd_v_q      <= 1'b0;
      x_ready_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      wcnt_q      <= '0;
      prev_n_q    <= '0;
      for (int l = 0; l < PAR; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      rd_v_q <= 1'b0;
      if (w_we) begin
        wcnt_q   <= wcnt_d;
        prev_n_q <= bus_io.config_neuron_num;
      end
      if (rd_v_q) begin
        for (int l = 0; l < PAR; l++) begin
          acc_q[l] <= acc_q[l] + AccW'(prod[l]);
        end
      end
      unique case (state_q)
        StIdle, StLoad: begin
          if (beat) begin
            if (cnt_q == CntW'(NUM_IN - 1)) begin
              cnt_q     <= '0;
              state_q   <= StCompute;
              x_ready_q <= 1'b0;
              nbase_q   <= '0;
              rbase_q   <= '0;
              c_q       <= '0;
              for (int l = 0; l < PAR; l++) begin
                acc_q[l] <= '0;
              end
            end else begin
              cnt_q   <= cnt_q + CntW'(1);
              state_q <= StLoad;
            end
          end
        end
        StCompute: begin
          // Read issued for c < NUM_IN; MAC lands one cycle later, then one drain cycle.
          rd_v_q <= (c_q < CntW'(NUM_IN));
          if (c_q == CntW'(NUM_IN + 1)) begin
            state_q <= StBias;
          end else begin
            c_q <= c_q + CntW'(1);
          end
        end
        StBias: begin
          for (int l = 0; l < PAR; l++) begin
            res_q[l] <= bres[l];
          end
          lane_q      <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= bres[0];
          out_idx_q   <= IdxW'(nbase_q);
          out_last_q  <= (nbase_q == NN - 1);
          state_q     <= StEmit;
        end
        StEmit: begin
          if (out_valid_q && bus_io.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              x_ready_q   <= 1'b1;
              state_q     <= StIdle;
            end else if (lane_q == LaneW'(PAR - 1)) begin
              out_valid_q <= 1'b0;
              nbase_q     <= nbase_q + PAR;
              rbase_q     <= rbase_q + NUM_IN;
              c_q         <= '0;
              state_q     <= StCompute;
              for (int l = 0; l < PAR; l++) begin
                acc_q[l] <= '0;
              end
            end else begin
              lane_q     <= nxt_lane;
              out_data_q <= res_q[nxt_lane];
              out_idx_q  <= IdxW'(cur_n + 32'd1);
              out_last_q <= ((cur_n + 32'd1) == NN - 1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.x_ready   = x_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_idx   = out_idx_q;
  assign bus_io.out_last  = out_last_q;

`ifdef LAYER_TM_ARGMAX_EN
  logic                     am_valid_q, have_q, better;
  logic [IdxW-1:0]          am_idx_q, best_idx_q, win_idx;
  logic signed [DATA_W-1:0] best_q;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    better  = !have_q || (out_data_q > best_q);
    win_idx = better ? out_idx_q : best_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      am_valid_q <= 1'b0;
      am_idx_q   <= '0;
      have_q     <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      am_valid_q <= 1'b0;
      if (beat && (state_q == StIdle)) begin
        have_q <= 1'b0;
      end
      if (out_valid_q && bus_io.out_ready) begin
        if (better) begin
          best_q     <= out_data_q;
          best_idx_q <= out_idx_q;
          have_q     <= 1'b1;
        end
        if (out_last_q) begin
          am_valid_q <= 1'b1;
          am_idx_q   <= win_idx;
        end
      end
    end
  end

  assign bus_io.argmax_valid = am_valid_q;
  assign bus_io.argmax_idx   = am_idx_q;
`else
  assign bus_io.argmax_valid = 1'b0;
  assign bus_io.argmax_idx   = '0;
`endif

endmodule

// File: tb/tb_layer_tm.sv
// Directed bench for layer_tm: three instances (relu, none, NN=5) share one config/input bus
// and are addressed through distinct LAYER_NUM values.
module tb_layer_tm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wv = 1'b0, bv = 1'b0, x_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] wval = '0, bval = '0, cfg_l = '0, cfg_n = '0;
  logic [15:0] x_in = '0;

  always #5 clk = ~clk;

  layer_tm_if #(.DataW(16), .IdxW(2)) if_r ();
  layer_tm_if #(.DataW(16), .IdxW(2)) if_n ();
  layer_tm_if #(.DataW(16), .IdxW(3)) if_p ();

  assign if_r.weightValid = wv;    assign if_n.weightValid = wv;    assign if_p.weightValid = wv;
  assign if_r.biasValid = bv;      assign if_n.biasValid = bv;      assign if_p.biasValid = bv;
  assign if_r.weightValue = wval;  assign if_n.weightValue = wval;  assign if_p.weightValue = wval;
  assign if_r.biasValue = bval;    assign if_n.biasValue = bval;    assign if_p.biasValue = bval;
  assign if_r.config_layer_num = cfg_l;  assign if_n.config_layer_num = cfg_l;
  assign if_p.config_layer_num = cfg_l;
  assign if_r.config_neuron_num = cfg_n; assign if_n.config_neuron_num = cfg_n;
  assign if_p.config_neuron_num = cfg_n;
  assign if_r.x_valid = x_valid;   assign if_n.x_valid = x_valid;   assign if_p.x_valid = x_valid;
  assign if_r.x_in = x_in;         assign if_n.x_in = x_in;         assign if_p.x_in = x_in;
  assign if_r.out_ready = out_ready; assign if_n.out_ready = out_ready;
  assign if_p.out_ready = out_ready;

  layer_tm #(.NN(4), .NUM_IN(3), .PAR(2), .DATA_W(16), .FRAC_W(8), .LAYER_NUM(2), .ACT("relu"))
    u_relu (.clk(clk), .rst(rst), .bus_io(if_r));
  layer_tm #(.NN(4), .NUM_IN(3), .PAR(2), .DATA_W(16), .FRAC_W(8), .LAYER_NUM(3), .ACT("none"))
    u_none (.clk(clk), .rst(rst), .bus_io(if_n));
  layer_tm #(.NN(5), .NUM_IN(3), .PAR(2), .DATA_W(16), .FRAC_W(8), .LAYER_NUM(4), .ACT("relu"))
    u_p5 (.clk(clk), .rst(rst), .bus_io(if_p));

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t q_r[$], q_n[$], q_p[$];
  int    am_cnt = 0;
  logic [2:0] am_idx = '0;

  always @(posedge clk) begin
    if (if_r.out_valid && if_r.out_ready) q_r.push_back({if_r.out_data, 1'b0, if_r.out_idx, if_r.out_last});
    if (if_n.out_valid && if_n.out_ready) q_n.push_back({if_n.out_data, 1'b0, if_n.out_idx, if_n.out_last});
    if (if_p.out_valid && if_p.out_ready) q_p.push_back({if_p.out_data, if_p.out_idx, if_p.out_last});
    if (if_p.argmax_valid) begin
      am_cnt <= am_cnt + 1;
      am_idx <= if_p.argmax_idx;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input logic [31:0] layer, input logic [31:0] n, input logic [15:0] v);
    cfg_l = layer; cfg_n = n; wval = {16'h0, v}; wv = 1'b1;
    tick();
    wv = 1'b0;
  endtask

  task automatic wr_b(input logic [31:0] layer, input logic [31:0] n, input logic [15:0] v);
    cfg_l = layer; cfg_n = n; bval = {16'h0, v}; bv = 1'b1;
    tick();
    bv = 1'b0;
  endtask

  task automatic load_layer(input logic [31:0] layer, input logic [3:0][15:0] w,
                            input logic [15:0] b2);
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) wr_w(layer, n, w[n]);
    end
    for (int n = 0; n < 4; n++) wr_b(layer, n, (n == 2) ? b2 : 16'h0);
  endtask

  task automatic send_frame(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    logic [2:0][15:0] xs;
    xs = {x2, x1, x0};
    for (int k = 0; k < 3; k++) begin
      chk("x_ready_load", 32'(if_r.x_ready), 32'd1);
      x_valid = 1'b1;
      x_in = xs[k];
      tick();
    end
    x_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(if_r.x_ready && if_n.x_ready && if_p.x_ready) && t < 400) begin
      tick();
      t++;
    end
    chk("idle_timeout", 32'(t < 400), 32'd1);
  endtask

  task automatic check_r600(input string tag);
    chk({tag, "_count"}, 32'(q_r.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_r.size()) begin
        chk({tag, "_data"}, 32'(q_r[i].d), 32'h0600);
        chk({tag, "_idx"}, 32'(q_r[i].idx), 32'(i));
      end
    end
  endtask

  typedef struct {
    logic [2:0][15:0] x;
    logic [3:0][15:0] wr;
    logic [3:0][15:0] wn;
    logic [15:0]      b2;
    logic [3:0][15:0] er;
    logic [3:0][15:0] en;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{x: {16'h0300, 16'h0200, 16'h0100},
                wr: {4{16'h0100}}, wn: {4{16'h0100}}, b2: 16'h0,
                er: {4{16'h0600}}, en: {4{16'h0600}}};
    vecs[1] = '{x: {16'h0300, 16'h0200, 16'h0100},
                wr: {16'h0100, 16'h0100, 16'hFF00, 16'h0100},
                wn: {16'h0100, 16'h0100, 16'hFF00, 16'h0100}, b2: 16'h0080,
                er: {16'h0600, 16'h0680, 16'h0000, 16'h0600},
                en: {16'h0600, 16'h0680, 16'hFA00, 16'h0600}};
    vecs[2] = '{x: {3{16'h7FFF}}, wr: {4{16'h7FFF}}, wn: {4{16'h8000}}, b2: 16'h0,
                er: {4{16'h7FFF}}, en: {4{16'h8000}}};
    vecs[3] = '{x: {3{16'h7FFF}}, wr: {4{16'h8000}}, wn: {4{16'h7FFF}}, b2: 16'h0,
                er: {4{16'h0000}}, en: {4{16'h7FFF}}};
    vecs[4] = '{x: {16'h0300, 16'h0200, 16'h0100},
                wr: {4{16'h0100}}, wn: {4{16'h0100}}, b2: 16'h0,
                er: {4{16'h0600}}, en: {4{16'h0600}}};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_x_ready", 32'(if_r.x_ready), 32'd1);
    chk("rst_out_valid", 32'(if_r.out_valid), 32'd0);
    chk("rst_out_data", 32'(if_r.out_data), 32'd0);
    chk("rst_out_idx", 32'(if_r.out_idx), 32'd0);
    chk("rst_out_last", 32'(if_r.out_last), 32'd0);
    chk("rst_am_valid", 32'(if_p.argmax_valid), 32'd0);
    chk("rst_am_idx", 32'(if_p.argmax_idx), 32'd0);

    for (int v = 0; v < 5; v++) begin
      load_layer(2, vecs[v].wr, vecs[v].b2);
      load_layer(3, vecs[v].wn, vecs[v].b2);
      q_r.delete(); q_n.delete(); q_p.delete();
      out_ready = 1'b1;
      send_frame(vecs[v].x[0], vecs[v].x[1], vecs[v].x[2]);
      wait_idle();
      chk("vec_relu_count", 32'(q_r.size()), 32'd4);
      chk("vec_none_count", 32'(q_n.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < q_r.size()) begin
          chk("vec_relu_data", 32'(q_r[i].d), 32'(vecs[v].er[i]));
          chk("vec_relu_idx", 32'(q_r[i].idx), 32'(i));
          chk("vec_relu_last", 32'(q_r[i].last), 32'(i == 3));
        end
        if (i < q_n.size()) begin
          chk("vec_none_data", 32'(q_n[i].d), 32'(vecs[v].en[i]));
          chk("vec_none_idx", 32'(q_n[i].idx), 32'(i));
        end
      end
    end

    // Back-pressure at idx 1, plus a weight write that must be dropped during EMIT.
    q_r.delete(); q_n.delete(); q_p.delete();
    out_ready = 1'b0;
    send_frame(16'h0100, 16'h0200, 16'h0300);
    begin
      int t;
      t = 0;
      while (!if_r.out_valid && t < 100) begin
        tick();
        t++;
      end
      chk("stall_valid_timeout", 32'(t < 100), 32'd1);
    end
    chk("stall_first_idx", 32'(if_r.out_idx), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("stall_valid", 32'(if_r.out_valid), 32'd1);
      chk("stall_idx", 32'(if_r.out_idx), 32'd1);
      chk("stall_data", 32'(if_r.out_data), 32'h0600);
      chk("stall_x_ready", 32'(if_r.x_ready), 32'd0);
      tick();
    end
    wr_w(2, 0, 16'h0000);
    chk("stall_idx_after_wr", 32'(if_r.out_idx), 32'd1);
    out_ready = 1'b1;
    wait_idle();
    check_r600("stall");
    for (int i = 0; i < 4; i++) begin
      if (i < q_r.size()) chk("stall_last", 32'(q_r[i].last), 32'(i == 3));
    end
    q_r.delete();
    send_frame(16'h0100, 16'h0200, 16'h0300);
    wait_idle();
    check_r600("emit_wr_dropped");

    // Reset while computing abandons the frame; weights survive.
    q_r.delete();
    send_frame(16'h0100, 16'h0200, 16'h0300);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(if_r.out_valid), 32'd0);
    chk("midrst_x_ready", 32'(if_r.x_ready), 32'd1);
    repeat (15) tick();
    chk("midrst_no_beats", 32'(q_r.size()), 32'd0);
    send_frame(16'h0100, 16'h0200, 16'h0300);
    wait_idle();
    check_r600("post_rst");

    // NN=5 instance: last group has one live lane; argmax on outputs 1,7,7,3,2.
    begin
      logic [4:0][15:0] pv;
      logic [4:0][15:0] ev;
      int am0;
      pv = {16'd2, 16'd3, 16'd7, 16'd7, 16'd1};
      ev = pv;
      for (int n = 0; n < 5; n++) begin
        wr_w(4, n, pv[n]);
        wr_w(4, n, 16'h0);
        wr_w(4, n, 16'h0);
      end
      for (int n = 0; n < 5; n++) wr_b(4, n, 16'h0);
      q_p.delete();
      am0 = am_cnt;
      send_frame(16'h0100, 16'h0000, 16'h0000);
      wait_idle();
      tick();
      tick();
      chk("p5_count", 32'(q_p.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
        if (i < q_p.size()) begin
          chk("p5_data", 32'(q_p[i].d), 32'(ev[i]));
          chk("p5_idx", 32'(q_p[i].idx), 32'(i));
          chk("p5_last", 32'(q_p[i].last), 32'(i == 4));
        end
      end
`ifdef LAYER_TM_ARGMAX_EN
      chk("argmax_pulses", 32'(am_cnt - am0), 32'd1);
      chk("argmax_idx", 32'(am_idx), 32'd1);
`else
      chk("argmax_pulses_off", 32'(am_cnt - am0), 32'd0);
      chk("argmax_idx_off", 32'(if_p.argmax_idx), 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_tm.md
Name: layer_tm

Overview:
- Time-multiplexed fully-connected layer: NN neurons evaluated by PAR shared signed MAC lanes over one frame of NUM_IN serial inputs.
- Successor to the fully-parallel per-neuron layer: generalised neuron count, fan-in and parallelism.
- Adds a frame input buffer, valid/ready handshakes, saturation, selectable activation and a serialised output stream.
- Sits between neural layers: consumes the upstream x stream and feeds the next layer's x_in/x_valid.

Parameters:
- NN, 30, neurons in layer
- NUM_IN, 784, inputs per frame (fan-in)
- PAR, 5, MAC lanes; 1 <= PAR <= NN
- DATA_W, 16, signed data/weight/bias width
- FRAC_W, 12, fractional bits of data, weights and biases
- LAYER_NUM, 2, layer id matched against config_layer_num
- ACT, "relu", "relu" or "none"

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- weightValid  in  1  weight write strobe
- biasValid  in  1  bias write strobe
- weightValue  in  32  weight, low DATA_W bits used
- biasValue  in  32  bias, low DATA_W bits used
- config_layer_num  in  32  write accepted only if equal to LAYER_NUM
- config_neuron_num  in  32  target neuron, 0..NN-1
- x_valid  in  1  input beat valid
- x_ready  out  1  input beat accepted when x_valid&x_ready
- x_in  in  DATA_W  input sample
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  activated neuron output
- out_idx  out  $clog2(NN)  neuron index of out_data
- out_last  out  1  high on beat with out_idx==NN-1
- argmax_valid  out  1  argmax result strobe (optional feature)
- argmax_idx  out  $clog2(NN)  argmax neuron (optional feature)

Behaviour:
- Reset (synchronous): FSM->IDLE; x_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, argmax_valid=0, argmax_idx=0. Counters cleared. Weight/bias memories not cleared; contents survive reset.
- Config writes:
  - Accepted only in IDLE with no frame beat yet taken; otherwise dropped silently.
  - A weight write goes to element wcnt of neuron config_neuron_num. wcnt increments per accepted write, wraps at NUM_IN, and clears when config_neuron_num differs from the previous accepted write.
  - A bias write goes to bias[config_neuron_num]. Indices >= NN are dropped.
  - Weights are stored in PAR banks: bank = n % PAR, address = (n/PAR)*NUM_IN + k.
- FSM:
  - IDLE/LOAD: x_ready=1; each handshake stores x_in at ibuf[cnt++]. On the NUM_IN-th beat go to COMPUTE; x_ready=0 from the next cycle.
  - COMPUTE: group g covers neurons g*PAR .. min(g*PAR+PAR, NN)-1. For k = 0..NUM_IN-1, each lane adds ibuf[k]*w[n][k] to its accumulator. Pipeline is memory read (1 cycle) then multiply-accumulate (1 cycle), so the group takes NUM_IN+2 cycles, then BIAS.
  - BIAS (1 cycle): acc += bias << FRAC_W, then arithmetic shift right by FRAC_W, saturate to signed DATA_W, apply activation (relu maps negative to 0). Results are latched to lane registers.
  - EMIT: lane results are emitted in ascending index, one per out_valid&out_ready. Lanes beyond NN in the last partial group are skipped. out_data/out_idx/out_last stay stable while out_valid&!out_ready. After the last lane, go to the next group's COMPUTE, or to IDLE after neuron NN-1.
- Arithmetic: product 2*DATA_W bits; accumulator width 2*DATA_W + $clog2(NUM_IN)+1, never wraps.
- Throughput: the next frame cannot be loaded until the current frame is fully emitted.
- x_valid is ignored while x_ready=0.
- Reset mid-frame abandons the frame immediately; out_valid=0 on the cycle after rst.

Optional Feature:
- Macro: LAYER_TM_ARGMAX_EN.
- Enabled: a running max of emitted out_data (signed compare, ties keep the lower index) is kept per frame. On the cycle after the out_last handshake, argmax_valid=1 for one cycle with argmax_idx = the winning neuron. The tracker clears at frame start.
- Disabled: argmax_valid and argmax_idx tied to 0; no tracker logic.

Test Plan:
- NN=4, NUM_IN=3, PAR=2, DATA_W=16, FRAC_W=8. All weights 0x0100, biases 0, inputs 0x0100/0x0200/0x0300 -> four beats of 0x0600, idx 0..3, out_last only on idx 3.
- Same setup, neuron 1 weights 0xFF00 -> idx1=0x0000 with ACT="relu"; idx1=0xFA00 with ACT="none". Bias 0x0080 on neuron 2 -> 0x0680.
- Weights 0x7FFF, inputs 0x7FFF -> every out_data=0x7FFF. Weights 0x8000, inputs 0x7FFF, ACT="none" -> 0x8000.
- out_ready low 5 cycles at idx 1 -> out_data/out_idx held, no beat lost or duplicated. x_ready=0 throughout; weight write during EMIT dropped (next frame unchanged).
- rst pulsed in COMPUTE -> out_valid=0, x_ready=1 next cycle; next frame returns 0x0600 results without reloading weights.
- NN=5, PAR=2 with LAYER_TM_ARGMAX_EN, neuron outputs 1,7,7,3,2 -> last group emits only idx 4; argmax_valid pulses once with argmax_idx=1.
